// File: rtl/serial_complement16.sv
// serial_complement16: bit-serial NOT/NEG/ABS/PASS unit, one bit per clock, LSB first
// ports: clk, rst (async, active high); start, op[1:0] (00 NOT, 01 NEG, 10 ABS, 11 PASS), In;
//        busy, done (level), Out (result register), ovf (negated most-negative value), zero
module serial_complement16 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] In,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Out,
   output logic             ovf,
   output logic             zero
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] opnd, res, res_n;
   logic [CW-1:0] cnt;
   logic carry, inv, ovf_p, accept, last, a, r, neg_eff;
   // NOT and negate both invert each bit; negate additionally ripples the +1 carry
   always_comb begin
      accept  = (state != RUN) && start;
      last    = (state == RUN) && (cnt == CW'(WIDTH-1));
      a       = opnd[0];
      r       = a ^ inv ^ carry;
      res_n   = {r, res[WIDTH-1:1]};
      neg_eff = (op == 2'b01) || ((op == 2'b10) && In[WIDTH-1]);
      state_n = accept ? RUN : last ? DONE : state;
      busy    = state == RUN;
      done    = state == DONE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         opnd  <= '0;
         res   <= '0;
         cnt   <= '0;
         carry <= 1'b0;
         inv   <= 1'b0;
         ovf_p <= 1'b0;
         Out   <= '0;
         ovf   <= 1'b0;
         zero  <= 1'b0;
      end else if (accept) begin
         opnd  <= In;
         cnt   <= '0;
         carry <= neg_eff;
         inv   <= neg_eff || (op == 2'b00);
         ovf_p <= neg_eff && (In == {1'b1, {(WIDTH-1){1'b0}}});
      end else if (state == RUN) begin
         opnd  <= opnd >> 1;
         res   <= res_n;
         cnt   <= cnt + 1'b1;
         carry <= ~a & carry;
         if (last) begin
            Out  <= res_n;
            zero <= res_n == '0;
            ovf  <= ovf_p;
         end
      end
endmodule

// File: tb/tb_serial_complement16.sv
// tb_serial_complement16: directed vector bench for serial_complement16
module tb_serial_complement16;
   logic clk = 0, rst = 1, start = 0;
   logic [1:0] op = 0;
   logic [15:0] In = 0;
   logic busy, done, ovf, zero;
   logic [15:0] Out;
   int tests = 0, fails = 0;

   serial_complement16 #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .In(In),
      .busy(busy), .done(done), .Out(Out), .ovf(ovf), .zero(zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [15:0] in;
      logic [15:0] out;
      logic        ovf;
      logic        zero;
   } vec_t;
   vec_t v[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_op(input int idx, input vec_t t);
      string n;
      n = $sformatf("vec%0d", idx);
      @(negedge clk);
      start = 1; op = t.op; In = t.in;
      @(posedge clk); #1;
      chk({n, " busy after accept"}, {31'd0, busy}, 1);
      chk({n, " done after accept"}, {31'd0, done}, 0);
      start = 0; In = ~t.in; op = ~t.op;
      repeat (15) @(posedge clk);
      #1;
      chk({n, " still busy at 15"}, {30'd0, busy, done}, 2'b10);
      @(posedge clk); #1;
      chk({n, " done at 16"}, {30'd0, busy, done}, 2'b01);
      chk({n, " Out"}, {16'd0, Out}, {16'd0, t.out});
      chk({n, " ovf"}, {31'd0, ovf}, {31'd0, t.ovf});
      chk({n, " zero"}, {31'd0, zero}, {31'd0, t.zero});
   endtask

   initial begin
      v[0] = '{2'b00, 16'h00F0, 16'hFF0F, 1'b0, 1'b0};
      v[1] = '{2'b01, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
      v[2] = '{2'b01, 16'h0000, 16'h0000, 1'b0, 1'b1};
      v[3] = '{2'b01, 16'h8000, 16'h8000, 1'b1, 1'b0};
      v[4] = '{2'b10, 16'hFFFB, 16'h0005, 1'b0, 1'b0};
      v[5] = '{2'b10, 16'h1234, 16'h1234, 1'b0, 1'b0};
      v[6] = '{2'b11, 16'hA5A5, 16'hA5A5, 1'b0, 1'b0};
      v[7] = '{2'b10, 16'h8000, 16'h8000, 1'b1, 1'b0};
      v[8] = '{2'b00, 16'hFFFF, 16'h0000, 1'b0, 1'b1};
      v[9] = '{2'b11, 16'h8000, 16'h8000, 1'b0, 1'b0};
      #12;
      chk("reset state", {12'd0, busy, done, ovf, zero, Out}, 32'd0);
      @(negedge clk); rst = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("idle after reset", {30'd0, busy, done}, 0);
      for (int i = 0; i < 10; i++) do_op(i, v[i]);

      // mid-operation disturbance then back-to-back accept from DONE
      @(negedge clk);
      start = 1; op = 2'b01; In = 16'h0003;
      @(negedge clk);
      start = 0;
      repeat (4) @(negedge clk);
      start = 1; op = 2'b00; In = 16'hFFFF;
      @(negedge clk);
      start = 0;
      chk("disturb still busy", {31'd0, busy}, 1);
      chk("disturb Out held", {16'd0, Out}, {16'd0, 16'h8000});
      repeat (11) @(posedge clk);
      #1;
      chk("disturb done", {30'd0, busy, done}, 2'b01);
      chk("disturb Out", {16'd0, Out}, {16'd0, 16'hFFFD});
      @(negedge clk);
      start = 1; op = 2'b01; In = 16'h0002;
      @(posedge clk); #1;
      chk("b2b accepted", {30'd0, busy, done}, 2'b10);
      chk("b2b Out held", {16'd0, Out}, {16'd0, 16'hFFFD});
      repeat (15) @(posedge clk);
      #1;
      chk("b2b busy at 15", {30'd0, busy, done}, 2'b10);
      @(posedge clk); #1;
      start = 0;
      chk("b2b done", {30'd0, busy, done}, 2'b01);
      chk("b2b Out", {16'd0, Out}, {16'd0, 16'hFFFE});

      // reset aborts a run
      @(negedge clk);
      start = 1; op = 2'b00; In = 16'h1111;
      @(negedge clk);
      start = 0;
      repeat (7) @(negedge clk);
      rst = 1;
      #1;
      chk("abort state", {12'd0, busy, done, ovf, zero, Out}, 32'd0);
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk($sformatf("no done after abort %0d", i), {30'd0, busy, done}, 0);
      end
      chk("Out after abort", {16'd0, Out}, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
